expand_burst: RTL and testbench

Burst expander: consumes burst descriptors `{burst_len, base_addr}` from an upstream FIFO and re-emits one beat address per data word, `burst_len + 1` beats per descriptor, each tagged with a last-beat flag. It sits on the memory-side path, where merged address bursts must be turned back into per-beat addresses. It reads descriptors at full throughput with no bubble between bursts and honours FIFO backpressure on both sides.

---
 rtl/expand_burst.sv | 87 ++++++++
 tb/tb_expand_burst.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/expand_burst.sv
// Burst expander: turns {len, addr} descriptors into len+1 per-beat
// addresses tagged with a last-beat flag, one beat per cycle.
module expand_burst #(
  parameter int unsigned AddrWidth         = 64,
  parameter int unsigned DataWidthBytesLog = 6,
  parameter int unsigned BurstLenWidth     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BurstLenWidth+AddrWidth-1:0] burst_dout,
  input  logic                           burst_empty_n,
  output logic                           burst_read,
  output logic [AddrWidth:0]             beat_din,
  input  logic                           beat_full_n,
  output logic                           beat_write
);

  localparam int unsigned HiWidth = AddrWidth - DataWidthBytesLog;
  localparam logic [HiWidth-1:0]       HiOne  = HiWidth'(1);
  localparam logic [BurstLenWidth-1:0] LenOne = BurstLenWidth'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [AddrWidth-1:0]     cur_addr, addr_next;
  logic [BurstLenWidth-1:0] remaining, rem_next;

  logic                     active;
  logic                     last_beat;
  logic [BurstLenWidth-1:0] desc_len;
  logic [AddrWidth-1:0]     desc_addr;
  logic [HiWidth-1:0]       addr_hi_inc;

  assign active      = (state == BURST);
  assign last_beat   = active && (remaining == '0);
  assign desc_len    = burst_dout[BurstLenWidth+AddrWidth-1:AddrWidth];
  assign desc_addr   = burst_dout[AddrWidth-1:0];
  assign addr_hi_inc = cur_addr[AddrWidth-1:DataWidthBytesLog] + HiOne;

  // State register: FSM state, current beat address and beats left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      cur_addr  <= addr_next;
      remaining <= rem_next;
    end
  end

  // Next-state: load a descriptor, step through its beats, or go idle
  always_comb begin
    state_next = state;
    addr_next  = cur_addr;
    rem_next   = remaining;
    if (burst_read) begin
      // A pop while active can only coincide with the final beat write,
      // so loading the new descriptor also retires the old burst.
      state_next = BURST;
      addr_next  = desc_addr;
      rem_next   = desc_len;
    end else if (beat_write) begin
      if (remaining != '0) begin
        rem_next  = remaining - LenOne;
        // Only the beat-index bits step; the byte offset is carried as-is.
        addr_next = {addr_hi_inc, cur_addr[DataWidthBytesLog-1:0]};
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Outputs: beat push, descriptor pop and the tagged beat word
  always_comb begin
    beat_write = active && beat_full_n;
    // Held low while reset is asserted so no pop escapes before release.
    burst_read = rst_n && burst_empty_n &&
                 (!active || (beat_write && (remaining == '0)));
    beat_din   = {last_beat, cur_addr};
  end

endmodule

// File: tb/tb_expand_burst.sv
// Testbench for expand_burst: directed scenarios plus random traffic,
// checked against a beat-level reference model.
module tb_expand_burst;

  localparam int unsigned AW = 64;
  localparam int unsigned LW = 8;

  typedef struct {
    logic [LW-1:0] len;
    logic [AW-1:0] addr;
  } desc_t;

  logic            clk;
  logic            rst_n;
  logic [LW+AW-1:0] burst_dout;
  logic            burst_empty_n;
  logic            burst_read;
  logic [AW:0]     beat_din;
  logic            beat_full_n;
  logic            beat_write;

  int unsigned n_cmp;
  int unsigned n_err;

  desc_t          dq[$];
  logic [AW:0]    exp_beats[$];
  int unsigned    pending;

  expand_burst #(
    .AddrWidth        (64),
    .DataWidthBytesLog(6),
    .BurstLenWidth    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .burst_dout   (burst_dout),
    .burst_empty_n(burst_empty_n),
    .burst_read   (burst_read),
    .beat_din     (beat_din),
    .beat_full_n  (beat_full_n),
    .beat_write   (beat_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW:0] obs, input logic [AW:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Queue a descriptor and expand it into expected beats: beat i sits
  // i*64 bytes past the base, wrapping modulo 2^64.
  task automatic push_desc(input int unsigned len, input logic [AW-1:0] addr);
    desc_t d;
    d.len  = LW'(len);
    d.addr = addr;
    dq.push_back(d);
    for (int unsigned i = 0; i <= len; i++) begin
      exp_beats.push_back({(i == len), addr + (64'(i) * 64'd64)});
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle, advance model at edge.
  task automatic cycle(input logic full_n);
    logic exp_wr, exp_rd;
    @(negedge clk);
    beat_full_n   = full_n;
    burst_empty_n = (dq.size() > 0);
    burst_dout    = (dq.size() > 0) ? {dq[0].len, dq[0].addr} : '0;
    #2;
    exp_wr = full_n && (pending > 0);
    exp_rd = (dq.size() > 0) && ((pending == 0) || (full_n && (pending == 1)));
    check("beat_write", {64'd0, beat_write}, {64'd0, exp_wr});
    check("burst_read", {64'd0, burst_read}, {64'd0, exp_rd});
    if (pending > 0) check("beat_din", beat_din, exp_beats[0]);
    else             check("idle_last", {64'd0, beat_din[AW]}, 65'd0);
    @(posedge clk);
    if (exp_wr) begin
      void'(exp_beats.pop_front());
      pending--;
    end
    if (exp_rd) begin
      pending += int'(dq[0].len) + 1;
      void'(dq.pop_front());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pending = 0;
    rst_n = 1'b0;
    beat_full_n = 1'b1;
    burst_empty_n = 1'b1;
    burst_dout = {8'd3, 64'h1000};

    // Reset state, before any clock edge
    #3;
    check("rst_beat_write", {64'd0, beat_write}, 65'd0);
    check("rst_burst_read", {64'd0, burst_read}, 65'd0);
    check("rst_beat_din", beat_din, 65'd0);
    @(negedge clk);
    burst_empty_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single burst
    push_desc(3, 64'h1000);
    repeat (6) cycle(1'b1);

    // Back-to-back singles
    push_desc(0, 64'h0);
    push_desc(0, 64'h40);
    push_desc(0, 64'h200);
    push_desc(0, 64'h1000);
    push_desc(0, 64'h8);
    repeat (8) cycle(1'b1);

    // Backpressure mid-burst with another descriptor waiting
    push_desc(2, 64'h2000);
    cycle(1'b1);
    cycle(1'b1);
    push_desc(0, 64'h3000);
    repeat (3) cycle(1'b0);
    repeat (5) cycle(1'b1);

    // Address wrap and unaligned offset
    push_desc(1, 64'hFFFF_FFFF_FFFF_FFC0);
    push_desc(1, 64'h1005);
    repeat (6) cycle(1'b1);

    // Max length followed by a queued descriptor
    push_desc(255, 64'h0);
    push_desc(0, 64'h5000);
    repeat (260) cycle(1'b1);

    // Reset asserted during beat 2 of a burst
    push_desc(7, 64'h100);
    cycle(1'b1);
    cycle(1'b1);
    @(negedge clk);
    beat_full_n   = 1'b1;
    burst_empty_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_beat_write", {64'd0, beat_write}, 65'd0);
    check("midrst_burst_read", {64'd0, burst_read}, 65'd0);
    check("midrst_beat_din", beat_din, 65'd0);
    repeat (pending) void'(exp_beats.pop_front());
    pending = 0;
    @(negedge clk);
    burst_empty_n = 1'b0;
    rst_n = 1'b1;
    repeat (4) cycle(1'b1);

    // Random traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      if (dq.size() < 4 && $urandom_range(0, 3) == 0) begin
        int unsigned l;
        l = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
        push_desc(l, {$urandom, $urandom});
      end
      cycle($urandom_range(0, 3) != 0);
    end

    // Drain remaining work, bounded
    for (int c = 0; c < 3000 && (dq.size() > 0 || pending > 0); c++) cycle(1'b1);
    check("drained_beats", 65'(exp_beats.size()), 65'd0);
    cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
